// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   // Bit positions of the inter-stage registers in the internal we/fl vectors
   localparam int STG_IF_ID  = 0;
   localparam int STG_ID_EX  = 1;
   localparam int STG_EX_MEM = 2;
   localparam int STG_MEM_WB = 3;
   localparam int NUM_STG    = 4;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Purpose: load-use hazard compare between the EX load and the ID sources.
// Latency: combinational, same cycle.
// Backpressure: none; consumer decides whether the hazard wins priority.
module pipe_ctrl_hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   output logic                  load_use
);

   logic rd_live;
   logic rs1_hit;
   logic rs2_hit;

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   always_comb begin
      rd_live  = ex_mem_read & ex_reg_write & (ex_rd != '0);
      rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
      rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
      load_use = rd_live & (rs1_hit | rs2_hit);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: pipeline sequencer driving per-stage write-enable/flush and PC write.
// Latency: control outputs combinational from registered state + inputs (same edge).
// Backpressure: freezes upstream stages (we=0) and inserts bubbles (we=1, fl=1).
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  ex_mdu_start,
   input  logic                  mdu_done,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   input  logic                  trap,
   output logic                  pc_we,
   output logic                  we_if_id,
   output logic                  we_id_ex,
   output logic                  we_ex_mem,
   output logic                  we_mem_wb,
   output logic                  fl_if_id,
   output logic                  fl_id_ex,
   output logic                  fl_ex_mem,
   output logic                  fl_mem_wb,
   output logic                  mdu_abort,
   output logic                  bus_err,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic               load_use;
   logic               mem_wait;
   logic               mdu_wait;
   logic               timeout;
   logic               pc_we_c;
   logic [NUM_STG-1:0] we_c;
   logic [NUM_STG-1:0] fl_c;
   logic               mdu_abort_c;
   logic               bus_err_c;

   pipe_ctrl_hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .load_use     (load_use)
   );

   // Priority resolution: trap/timeout > memory wait > MDU wait > branch > load-use
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = '0;
      pc_we_c     = 1'b1;
      we_c        = '1;
      fl_c        = '0;
      mdu_abort_c = 1'b0;
      bus_err_c   = 1'b0;

      mem_wait = dmem_req & ~dmem_ready;
      // MEM_WAIT only lasts while the access is pending, so once it releases the
      // MDU check behaves as in RUN; a held MDU op is not let through early.
      mdu_wait = ex_mdu_start & ~mdu_done;
      timeout  = mem_wait & (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

      if (trap || timeout) begin
         fl_c        = '1;
         mdu_abort_c = (state_q == MDU_WAIT);
         bus_err_c   = timeout;
         state_d     = RUN;
      end else if (mem_wait) begin
         pc_we_c            = 1'b0;
         we_c[STG_IF_ID]    = 1'b0;
         we_c[STG_ID_EX]    = 1'b0;
         we_c[STG_EX_MEM]   = 1'b0;
         fl_c[STG_MEM_WB]   = 1'b1;
         wait_cnt_d         = wait_cnt_q + WAIT_W'(1);
         // An MDU op already waiting keeps its state so a later trap still aborts it
         state_d            = (state_q == MDU_WAIT) ? MDU_WAIT : MEM_WAIT;
      end else if (mdu_wait) begin
         pc_we_c            = 1'b0;
         we_c[STG_IF_ID]    = 1'b0;
         we_c[STG_ID_EX]    = 1'b0;
         fl_c[STG_EX_MEM]   = 1'b1;
         state_d            = MDU_WAIT;
      end else begin
         state_d = RUN;
         if (ex_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use on it is moot
            fl_c[STG_IF_ID] = 1'b1;
            fl_c[STG_ID_EX] = 1'b1;
         end else if (load_use) begin
            pc_we_c         = 1'b0;
            we_c[STG_IF_ID] = 1'b0;
            fl_c[STG_ID_EX] = 1'b1;
         end
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_we_c && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State, wait counter and stall counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Outputs forced low while reset is asserted, without waiting for a clock
   always_comb begin
      pc_we     = pc_we_c & ~rst;
      we_if_id  = we_c[STG_IF_ID]  & ~rst;
      we_id_ex  = we_c[STG_ID_EX]  & ~rst;
      we_ex_mem = we_c[STG_EX_MEM] & ~rst;
      we_mem_wb = we_c[STG_MEM_WB] & ~rst;
      fl_if_id  = fl_c[STG_IF_ID]  & ~rst;
      fl_id_ex  = fl_c[STG_ID_EX]  & ~rst;
      fl_ex_mem = fl_c[STG_EX_MEM] & ~rst;
      fl_mem_wb = fl_c[STG_MEM_WB] & ~rst;
      mdu_abort = mdu_abort_c & ~rst;
      bus_err   = bus_err_c & ~rst;
      stall_cnt = stall_cnt_q;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage core.
- Drives the write_enable/flush pair of each inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC write enable.
- Resolves load-use hazards, taken branches, multi-cycle MDU ops, data-memory wait states and traps.
- Keeps a stall performance counter.

Parameters:
- REG_ADDR_W, 5: register index width.
- MEM_TIMEOUT, 255: maximum data-memory wait cycles before a bus error.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  clock; pipeline registers also sample on posedge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  each source is actually read.
- ex_rd  in  REG_ADDR_W  destination of the instruction in EX.
- ex_reg_write, ex_mem_read  in  1  the EX instruction writes a register / is a load.
- ex_branch_taken  in  1  EX resolved a redirect.
- ex_mdu_start  in  1  the EX instruction is a multi-cycle MDU op.
- mdu_done  in  1  MDU result valid this cycle.
- dmem_req, dmem_ready  in  1  MEM-stage access pending / completes this cycle.
- trap  in  1  exception raised by the MEM-stage instruction.
- pc_we  out  1  PC write enable.
- we_if_id, we_id_ex, we_ex_mem, we_mem_wb  out  1  pipeline register enables.
- fl_if_id, fl_id_ex, fl_ex_mem, fl_mem_wb  out  1  pipeline register flushes.
- mdu_abort  out  1  kill the in-flight MDU op.
- bus_err  out  1  one-cycle pulse on memory timeout.
- stall_cnt  out  CNT_W  count of cycles with pc_we=0.

Behaviour:
- Pipeline registers honour flush only when write_enable=1. Every flush is therefore issued with its we=1. A bubble is we=1, fl=1. A freeze is we=0.
- Control outputs are combinational from the registered state and current inputs, so control takes effect on the same edge.
- State, wait counter and stall_cnt are registered.
- FSM states: RUN, MDU_WAIT, MEM_WAIT.
- During rst: state=RUN, wait_cnt=0, stall_cnt=0. All we/fl=0, pc_we=0, mdu_abort=0, bus_err=0.
- Default (no event): all we=1, all fl=0, pc_we=1.
- Priority, highest first: trap > memory wait > MDU wait > branch > load-use.
- trap (any state):
  - pc_we=1; all four we=1, fl=1.
  - mdu_abort=1 if state=MDU_WAIT.
  - Next state RUN, wait_cnt cleared.
- Memory wait:
  - Condition: dmem_req & !dmem_ready.
  - pc_we, we_if_id, we_id_ex, we_ex_mem = 0; MEM/WB bubble.
  - State MEM_WAIT, wait_cnt increments each cycle.
  - On dmem_ready: default outputs, go to RUN.
  - If wait_cnt reaches MEM_TIMEOUT: bus_err=1 for one cycle, treated exactly as trap that cycle, go to RUN.
- MDU:
  - Condition: ex_mdu_start & !mdu_done in RUN or MDU_WAIT.
  - pc_we, we_if_id, we_id_ex = 0; EX/MEM bubble; state MDU_WAIT.
  - Cycle with mdu_done: default outputs (the op advances), go to RUN.
  - Single-cycle op (start & done together): no stall.
  - A memory wait arising during MDU_WAIT freezes EX/MEM as well; MDU state is retained.
- Branch taken: IF/ID bubble, ID/EX bubble, pc_we=1. Suppresses any load-use stall the same cycle, since the ID instruction is wrong-path.
- Load-use:
  - Condition: ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - pc_we=0, we_if_id=0, ID/EX bubble.
  - Lasts exactly one cycle, because the load moves to MEM.
- stall_cnt increments on every non-reset cycle with pc_we=0; it saturates at all-ones.
- Reset mid-stall: returns to RUN immediately; no partial state survives.

Decomposition:
- pipe_ctrl_pkg holds the state enum (RUN, MDU_WAIT, MEM_WAIT) and the stage index constants.
- Sub-module hazard_detect: combinational load-use compare, output load_use.

Test Plan:
- Load x5 in EX (ex_rd=5, ex_mem_read=1), ID reads rs1=5 -> one cycle: pc_we=0, we_if_id=0, we_id_ex=1, fl_id_ex=1; next cycle defaults; stall_cnt=1.
- Same hazard with ex_rd=0, or id_use_rs1=0 -> no stall.
- Load-use and ex_branch_taken together -> fl_if_id=fl_id_ex=1, pc_we=1, stall_cnt unchanged.
- ex_mdu_start held, mdu_done after 4 cycles -> 4 cycles frozen with EX/MEM bubble, state MDU_WAIT; done cycle defaults; stall_cnt=4.
- trap during MDU_WAIT cycle 2 -> mdu_abort=1, all fl=1 with we=1, pc_we=1; next cycle RUN.
- MEM_TIMEOUT=8, dmem_req=1, dmem_ready=0 -> 8 frozen cycles with MEM/WB bubble, then bus_err pulse plus a full flush.
- Repeat with dmem_ready at cycle 3 -> no bus_err, release at cycle 3.
- Assert rst mid-MEM_WAIT -> outputs 0 asynchronously, stall_cnt=0, state RUN after release.
